// File: rtl/stn2tft_pkg.sv
// Shared geometry defaults and small helpers for the STN-to-TFT converter core.
// Bit positions describe how the STN pins are bundled through the synchronizer.
package stn2tft_pkg;

    localparam int H_BYTES_DEF = 40;
    localparam int V_LINES_DEF = 240;

    localparam int BUS_W     = 7;
    localparam int FRAME_BIT = 6;
    localparam int LINE_BIT  = 5;
    localparam int SHIFT_BIT = 4;

    function automatic logic [7:0] pack_byte(input logic [3:0] hi, input logic [3:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/stn_sync3.sv
// N-bit three-flop synchronizer; exposes the last two stages for edge decode.
module stn_sync3 #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] s2,
    output logic [N-1:0] s3
);

    logic [N-1:0] s1_r;

    // Three-stage shift of the asynchronous bus into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= '0;
            s2   <= '0;
            s3   <= '0;
        end else begin
            s1_r <= d;
            s2   <= s1_r;
            s3   <= s2;
        end
    end

endmodule

// File: rtl/stn_capture.sv
// STN panel bus capture: synchronizes the panel pins, packs nibble pairs into
// bytes and emits x/y addressed writes plus frame/line markers and error flags.
module stn_capture
    import stn2tft_pkg::*;
#(
    parameter int H_BYTES = H_BYTES_DEF,
    parameter int V_LINES = V_LINES_DEF,
    parameter int XW      = 6,
    parameter int YW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stn_fpframe,
    input  logic          stn_fpline,
    input  logic          stn_fpshift,
    input  logic [3:0]    stn_fpdat,
    output logic          wr_en,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [7:0]    wr_data,
    output logic          frame_start,
    output logic          line_done,
    output logic          err_h,
    output logic          err_v
);

    // Counters carry one spare bit so they can saturate at the limit itself.
    localparam logic [XW:0] X_LIM = (XW+1)'(H_BYTES);
    localparam logic [YW:0] Y_LIM = (YW+1)'(V_LINES);
    localparam logic [XW:0] X_ONE = {{XW{1'b0}}, 1'b1};
    localparam logic [YW:0] Y_ONE = {{YW{1'b0}}, 1'b1};

    logic [BUS_W-1:0] pins_s, s2_s, s3_s;
    logic             shift_fall_s, line_rise_s, frame_rise_s;
    logic [3:0]       dat_s;

    logic [XW:0]   x_r, x_nxt_s;
    logic [YW:0]   y_r, y_nxt_s;
    logic          phase_r, phase_nxt_s;
    logic [3:0]    hi_r, hi_nxt_s;
    logic          err_h_nxt_s, err_v_nxt_s;
    logic          wr_en_s, frame_start_s, line_done_s;
    logic [XW-1:0] wr_x_s;
    logic [YW-1:0] wr_y_s;
    logic [7:0]    wr_data_s;

    assign pins_s = {stn_fpframe, stn_fpline, stn_fpshift, stn_fpdat};

    stn_sync3 #(.N(BUS_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pins_s),
        .s2  (s2_s),
        .s3  (s3_s)
    );

    assign shift_fall_s = s3_s[SHIFT_BIT] & ~s2_s[SHIFT_BIT];
    assign line_rise_s  = s2_s[LINE_BIT]  & ~s3_s[LINE_BIT];
    assign frame_rise_s = s2_s[FRAME_BIT] & ~s3_s[FRAME_BIT];
    assign dat_s        = s2_s[3:0];

    // Event decode: frame beats everything; a shift is folded in before a line end.
    always_comb begin
        x_nxt_s       = x_r;
        y_nxt_s       = y_r;
        phase_nxt_s   = phase_r;
        hi_nxt_s      = hi_r;
        err_h_nxt_s   = err_h;
        err_v_nxt_s   = err_v;
        wr_en_s       = 1'b0;
        wr_x_s        = x_r[XW-1:0];
        wr_y_s        = y_r[YW-1:0];
        wr_data_s     = 8'h00;
        frame_start_s = 1'b0;
        line_done_s   = 1'b0;
        if (frame_rise_s) begin
            frame_start_s = 1'b1;
            x_nxt_s       = '0;
            y_nxt_s       = '0;
            phase_nxt_s   = 1'b0;
        end else begin
            if (shift_fall_s) begin
                if (!phase_r) begin
                    hi_nxt_s    = dat_s;
                    phase_nxt_s = 1'b1;
                end else begin
                    if ((x_r < X_LIM) && (y_r < Y_LIM)) begin
                        wr_en_s   = 1'b1;
                        wr_data_s = pack_byte(hi_r, dat_s);
                        x_nxt_s   = x_r + X_ONE;
                    end else begin
                        err_h_nxt_s = err_h | (x_r >= X_LIM);
                        err_v_nxt_s = err_v | (y_r >= Y_LIM);
                    end
                    phase_nxt_s = 1'b0;
                end
            end else begin
                hi_nxt_s = hi_r;
            end
            if (line_rise_s) begin
                if (phase_nxt_s) begin
                    if ((x_nxt_s < X_LIM) && (y_r < Y_LIM)) begin
                        wr_en_s   = 1'b1;
                        wr_x_s    = x_nxt_s[XW-1:0];
                        wr_data_s = pack_byte(hi_nxt_s, 4'h0);
                    end else begin
                        err_h_nxt_s = err_h_nxt_s | (x_nxt_s >= X_LIM);
                        err_v_nxt_s = err_v_nxt_s | (y_r >= Y_LIM);
                    end
                end else begin
                    wr_data_s = wr_data_s;
                end
                line_done_s = 1'b1;
                x_nxt_s     = '0;
                phase_nxt_s = 1'b0;
                y_nxt_s     = (y_r < Y_LIM) ? (y_r + Y_ONE) : y_r;
            end else begin
                line_done_s = 1'b0;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r         <= '0;
            y_r         <= '0;
            phase_r     <= 1'b0;
            hi_r        <= 4'h0;
            wr_en       <= 1'b0;
            wr_x        <= '0;
            wr_y        <= '0;
            wr_data     <= 8'h00;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            err_h       <= 1'b0;
            err_v       <= 1'b0;
        end else begin
            x_r         <= x_nxt_s;
            y_r         <= y_nxt_s;
            phase_r     <= phase_nxt_s;
            hi_r        <= hi_nxt_s;
            wr_en       <= wr_en_s;
            wr_x        <= wr_x_s;
            wr_y        <= wr_y_s;
            wr_data     <= wr_data_s;
            frame_start <= frame_start_s;
            line_done   <= line_done_s;
            err_h       <= err_h_nxt_s;
            err_v       <= err_v_nxt_s;
        end
    end

endmodule

// File: tb/tb_stn_capture.sv
// Scoreboard bench for stn_capture: expected writes are queued as the STN bus
// is driven and checked by a monitor as the design emits them.
module tb_stn_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stn_fpframe = 1'b0;
    logic       stn_fpline  = 1'b0;
    logic       stn_fpshift = 1'b0;
    logic [3:0] stn_fpdat   = 4'h0;
    logic       wr_en;
    logic [5:0] wr_x;
    logic [7:0] wr_y;
    logic [7:0] wr_data;
    logic       frame_start, line_done, err_h, err_v;

    typedef struct {
        logic [5:0] x;
        logic [7:0] y;
        logic [7:0] d;
        logic       ld;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ld_cnt = 0;
    int   fs_cnt = 0;

    always #5 clk = ~clk;

    stn_capture dut (
        .clk         (clk),
        .rst         (rst),
        .stn_fpframe (stn_fpframe),
        .stn_fpline  (stn_fpline),
        .stn_fpshift (stn_fpshift),
        .stn_fpdat   (stn_fpdat),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .line_done   (line_done),
        .err_h       (err_h),
        .err_v       (err_v)
    );

    // Monitor: pop and compare every write, count marker pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got x=%0d y=%0d d=%h, none expected", wr_x, wr_y, wr_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({wr_x, wr_y, wr_data, line_done} !== {e.x, e.y, e.d, e.ld}) begin
                        bad++;
                        $display("FAIL write: got x=%0d y=%0d d=%h ld=%b, want x=%0d y=%0d d=%h ld=%b",
                                 wr_x, wr_y, wr_data, line_done, e.x, e.y, e.d, e.ld);
                    end
                end
            end
            if (line_done === 1'b1) ld_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
        end
    end

    task automatic push(input int x, input int y, input logic [7:0] d, input logic ld);
        exp_t e;
        e.x = 6'(x); e.y = 8'(y); e.d = d; e.ld = ld;
        exp_q.push_back(e);
    endtask

    task automatic shift_nib(input logic [3:0] d);
        @(negedge clk);
        stn_fpdat   = d;
        stn_fpshift = 1'b1;
        repeat (4) @(negedge clk);
        stn_fpshift = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse(input logic fr, input logic ln);
        @(negedge clk);
        stn_fpframe = fr;
        stn_fpline  = ln;
        repeat (4) @(negedge clk);
        stn_fpframe = 1'b0;
        stn_fpline  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        repeat (8) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: %0d writes still pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({wr_en, wr_x, wr_y, wr_data, frame_start, line_done, err_h, err_v} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b x=%0d y=%0d d=%h fs=%b ld=%b eh=%b ev=%b, want all 0",
                     wr_en, wr_x, wr_y, wr_data, frame_start, line_done, err_h, err_v);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_line();
        int fs0, ld0;
        fs0 = fs_cnt;
        pulse(1'b1, 1'b0);
        check_cnt("full_frame_start", fs_cnt - fs0, 1);
        for (int i = 0; i < 40; i++) begin
            push(i, 0, 8'hA5, 1'b0);
            shift_nib(4'hA);
            shift_nib(4'h5);
        end
        ld0 = ld_cnt;
        pulse(1'b0, 1'b1);
        check_drained("full_line");
        check_cnt("full_line_done", ld_cnt - ld0, 1);
    endtask

    task automatic test_flush();
        int ld0;
        push(0, 1, 8'h12, 1'b0);
        shift_nib(4'h1);
        shift_nib(4'h2);
        shift_nib(4'h3);
        push(1, 1, 8'h30, 1'b1);
        ld0 = ld_cnt;
        pulse(1'b0, 1'b1);
        check_drained("flush");
        check_cnt("flush_line_done", ld_cnt - ld0, 1);
    endtask

    task automatic test_err_h();
        int fs0;
        pulse(1'b1, 1'b0);
        check_cnt("err_h_before", int'(err_h), 0);
        for (int i = 0; i < 41; i++) begin
            if (i < 40) push(i, 0, {4'(i), 4'hC}, 1'b0);
            shift_nib(4'(i));
            shift_nib(4'hC);
        end
        check_drained("err_h_line");
        check_cnt("err_h_set", int'(err_h), 1);
        pulse(1'b0, 1'b1);
        fs0 = fs_cnt;
        pulse(1'b1, 1'b0);
        check_cnt("err_h_frame_start", fs_cnt - fs0, 1);
        check_cnt("err_h_sticky", int'(err_h), 1);
    endtask

    task automatic test_err_v();
        int ld0;
        pulse(1'b1, 1'b0);
        ld0 = ld_cnt;
        for (int i = 0; i < 239; i++) pulse(1'b0, 1'b1);
        push(0, 239, 8'h7E, 1'b0);
        shift_nib(4'h7);
        shift_nib(4'hE);
        check_drained("last_line");
        check_cnt("err_v_before", int'(err_v), 0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check_cnt("err_v_line_done", ld_cnt - ld0, 241);
        shift_nib(4'h9);
        shift_nib(4'h6);
        check_drained("err_v_drop");
        check_cnt("err_v_set", int'(err_v), 1);
        pulse(1'b1, 1'b0);
        push(0, 0, 8'h3C, 1'b0);
        shift_nib(4'h3);
        shift_nib(4'hC);
        check_drained("err_v_recover");
        check_cnt("err_v_sticky", int'(err_v), 1);
    endtask

    task automatic test_collision();
        int fs0, ld0;
        shift_nib(4'hF);
        fs0 = fs_cnt;
        ld0 = ld_cnt;
        pulse(1'b1, 1'b1);
        check_drained("collision_noflush");
        check_cnt("collision_frame_start", fs_cnt - fs0, 1);
        check_cnt("collision_no_line_done", ld_cnt - ld0, 0);
        push(0, 0, 8'h81, 1'b0);
        shift_nib(4'h8);
        shift_nib(4'h1);
        check_drained("collision_next");
    endtask

    task automatic test_rst_mid();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            push(i, 1, {4'h2, 4'(i)}, 1'b0);
            shift_nib(4'h2);
            shift_nib(4'(i));
        end
        check_drained("rst_mid_bytes");
        shift_nib(4'hD);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({wr_en, wr_x, wr_y, wr_data, frame_start, line_done, err_h, err_v} !== 27'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got en=%b x=%0d y=%0d d=%h fs=%b ld=%b eh=%b ev=%b, want all 0",
                     wr_en, wr_x, wr_y, wr_data, frame_start, line_done, err_h, err_v);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push(0, 0, 8'h4B, 1'b0);
        shift_nib(4'h4);
        shift_nib(4'hB);
        check_drained("rst_mid_resume");
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_flush();
        test_err_h();
        test_err_v();
        test_collision();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
